sdm_cic_decim: RTL and testbench

Sigma-delta bitstream decimator: the receive-side counterpart of the second-order SDM DAC. Converts a 1-bit pulse-density stream into signed BITS-wide PCM samples with an ORDER-stage CIC (sinc^N) filter that decimates by 2^DECIM_LOG2. It sits between the 1-bit input pin (or an SDM loopback) and the sample-domain logic, such as the angle counter and CORDIC path.

---
 rtl/sdm_pkg.sv | 20 ++
 rtl/sdm_cic_decim_comb.sv | 82 ++++++++
 rtl/sdm_cic_decim.sv | 68 ++++++
 tb/tb_sdm_cic_decim.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Shared sigma-delta conventions: accumulator sizing, output scaling and the
// default sample limits, reused by both the SDM DAC and the CIC decimator.
package sdm_pkg;

  localparam int BITS_DEF = 16;

  localparam logic signed [BITS_DEF-1:0] SMAX = {1'b0, {(BITS_DEF-1){1'b1}}};
  localparam logic signed [BITS_DEF-1:0] SMIN = {1'b1, {(BITS_DEF-1){1'b0}}};

  // CIC gain is R^ORDER = 2^(order*dlog2); two extra bits hold the signed
  // +/- full-scale value without ambiguity.
  function automatic int acc_w(input int order, input int dlog2);
    return order * dlog2 + 2;
  endfunction

  function automatic int shift_amt(input int order, input int dlog2, input int bits);
    return order * dlog2 - (bits - 1);
  endfunction

endpackage

// File: rtl/sdm_cic_decim_comb.sv
// CIC comb section: captures the last integrator once per frame, runs the
// ORDER-stage differencing chain and scales the result to BITS.
// Optional clipping is enabled by defining SDM_DECIM_SAT_EN.
module cic_comb
  import sdm_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 6,
  parameter int ACC_W      = acc_w(ORDER, DECIM_LOG2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] sample,
  output logic [BITS-1:0]         dout,
  output logic                    dout_valid,
  output logic                    sat
);

  localparam int SH = shift_amt(ORDER, DECIM_LOG2, BITS);

  logic signed [ACC_W-1:0] s_reg;
  logic signed [ACC_W-1:0] d_reg [ORDER];
  logic signed [ACC_W-1:0] c_tap [ORDER];
  logic signed [ACC_W-1:0] acc;
  logic                    pend;
  logic [BITS-1:0]         sample_out;
  logic                    clip;

`ifdef SDM_DECIM_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (BITS-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
  logic signed [ACC_W-1:0] scaled;
`endif

  // NOTE: every variable written here gets a default before any branch so no
  // latch can be inferred; acc is walked down the chain as a running value.
  always_comb begin
    acc = s_reg;
    for (int k = 0; k < ORDER; k++) begin
      c_tap[k] = acc;
      acc      = acc - d_reg[k];
    end
`ifdef SDM_DECIM_SAT_EN
    scaled = acc >>> SH;
    clip   = (scaled > MAX_V) || (scaled < MIN_V);
    if (scaled > MAX_V)
      sample_out = MAX_V[BITS-1:0];
    else if (scaled < MIN_V)
      sample_out = MIN_V[BITS-1:0];
    else
      sample_out = scaled[BITS-1:0];
`else
    clip       = 1'b0;
    sample_out = BITS'(acc >>> SH);
`endif
  end

  // NOTE: the comb delay registers are a small array that must start at zero
  // for the transient response to be deterministic, so they are reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg      <= '0;
      pend       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
      for (int k = 0; k < ORDER; k++) d_reg[k] <= '0;
    end else begin
      if (load) s_reg <= sample;
      pend       <= load;
      dout_valid <= pend;
      sat        <= pend & clip;
      if (pend) begin
        for (int k = 0; k < ORDER; k++) d_reg[k] <= c_tap[k];
        dout <= sample_out;
      end
    end
  end

endmodule

// File: rtl/sdm_cic_decim.sv
// Sigma-delta bitstream to PCM decimator: ORDER-stage CIC, decimate by
// 2^DECIM_LOG2. Output clipping is enabled by defining SDM_DECIM_SAT_EN.
module sdm_cic_decim
  import sdm_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            din,
  output logic [BITS-1:0] dout,
  output logic            dout_valid,
  output logic            sat
);

  localparam int ACC_W = acc_w(ORDER, DECIM_LOG2);

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("sdm_cic_decim: ORDER must be in 1..4");
  end
  if (DECIM_LOG2 < 1) begin : g_bad_decim
    $error("sdm_cic_decim: DECIM_LOG2 must be at least 1");
  end
  if (ORDER * DECIM_LOG2 < BITS - 1) begin : g_bad_width
    $error("sdm_cic_decim: ORDER*DECIM_LOG2 must be >= BITS-1");
  end

  logic signed [ACC_W-1:0] integ [ORDER];
  logic [DECIM_LOG2-1:0]   cnt;
  logic signed [ACC_W-1:0] x;
  logic                    frame_end;

  assign x         = din ? ACC_W'(1) : '1;
  assign frame_end = en && (cnt == '1);

  // NOTE: non-blocking assignments make every stage read the previous
  // cycle's value of its predecessor, which is the intended one-cycle skew.
  // Integrator overflow wraps on purpose; the comb differences undo it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (en) begin
      cnt      <= cnt + 1'b1;
      integ[0] <= integ[0] + x;
      for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  cic_comb #(
    .BITS       (BITS),
    .ORDER      (ORDER),
    .DECIM_LOG2 (DECIM_LOG2),
    .ACC_W      (ACC_W)
  ) u_comb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (frame_end),
    .sample     (integ[ORDER-1]),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sat        (sat)
  );

endmodule

// File: tb/tb_sdm_cic_decim.sv
// Randomised and pattern-driven bench for sdm_cic_decim against a closed-form
// CIC model built from the strobed bit history.
module tb_sdm_cic_decim;

  localparam int BITS  = 16;
  localparam int ORDER = 3;
  localparam int DL    = 6;
  localparam int R     = 1 << DL;
  localparam int SH    = ORDER * DL - (BITS - 1);
  localparam longint MAXV = (longint'(1) << (BITS - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (BITS - 1));

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            din;
  logic [BITS-1:0] dout;
  logic            dout_valid;
  logic            sat;

  sdm_cic_decim #(.BITS(BITS), .ORDER(ORDER), .DECIM_LOG2(DL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     fr       = 0;
  int     seg      = 0;
  int     hist[$];
  int     due[$];
  longint last_dout = 0;
  bit     steady_on = 1'b0;
  longint steady_val = 0;
  bit     steady_sat = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint binom(input longint n, input int k);
    longint r = 1;
    if (n < k) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Last integrator after j strobes: sum of x_i weighted by C(j-1-i, ORDER-1).
  function automatic longint s_val(input int m);
    longint s = 0;
    int j;
    if (m < 0) return 0;
    j = m * R + R - 1;
    for (int i = 0; i < j; i++) s += binom(j - 1 - i, ORDER - 1) * hist[i];
    return s;
  endfunction

  // ORDER-fold lag-R difference of the frame samples.
  function automatic longint c_val(input int m);
    longint c = 0;
    for (int k = 0; k <= ORDER; k++)
      c += ((k % 2) ? -1 : 1) * binom(ORDER, k) * s_val(m - k);
    return c;
  endfunction

  function automatic longint exp_dout(input longint v);
    longint sc = v >>> SH;
`ifdef SDM_DECIM_SAT_EN
    if (sc > MAXV) return MAXV;
    if (sc < MINV) return MINV;
    return sc;
`else
    logic [BITS-1:0] lo = sc[BITS-1:0];
    return longint'($signed(lo));
`endif
  endfunction

  function automatic bit exp_sat(input longint v);
`ifdef SDM_DECIM_SAT_EN
    longint sc = v >>> SH;
    return (sc > MAXV) || (sc < MINV);
`else
    return (v != v);
`endif
  endfunction

  task automatic begin_seg(input bit on, input longint val, input bit s);
    steady_on  = on;
    steady_val = val;
    steady_sat = s;
    seg        = 0;
  endtask

  task automatic model_reset();
    hist.delete();
    due.delete();
    fr        = 0;
    last_dout = 0;
  endtask

  // Sample outputs at the falling edge, then drive this cycle's inputs.
  task automatic step(input logic e, input logic d);
    bit     exp_v;
    longint v, ed;
    @(negedge clk);
    cyc++;
    exp_v = (due.size() > 0) && (due[0] == cyc);
    if (exp_v) void'(due.pop_front());
    check("dout_valid", dout_valid, exp_v);
    if (exp_v) begin
      v  = c_val(fr);
      ed = exp_dout(v);
      check("dout", longint'($signed(dout)), ed);
      check("sat", sat, exp_sat(v));
      last_dout = ed;
      fr++;
      seg++;
      if (steady_on && seg >= 6) begin
        check("steady_dout", longint'($signed(dout)), steady_val);
        check("steady_sat", sat, steady_sat);
      end
    end else begin
      check("dout_hold", longint'($signed(dout)), last_dout);
      check("sat_idle", sat, 0);
    end
    en  = e;
    din = d;
    if (e) begin
      hist.push_back(d ? 1 : -1);
      if (hist.size() % R == 0) due.push_back(cyc + 2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    #1;
    check("rst_dout", longint'($signed(dout)), 0);
    check("rst_valid", dout_valid, 0);
    check("rst_sat", sat, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    begin_seg(1'b1, 0, 1'b0);
    for (int i = 0; i < 6 * R; i++) step(1'b1, (i % 2) == 0);

    begin_seg(1'b1, MINV, 1'b0);
    for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b0);
    while (hist.size() % R != 30) step(1'b1, 1'b0);

    check("pre_rst_dout", longint'($signed(dout)), MINV);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", longint'($signed(dout)), 0);
    check("async_rst_valid", dout_valid, 0);
    model_reset();
    en = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

`ifdef SDM_DECIM_SAT_EN
    begin_seg(1'b1, MAXV, 1'b1);
`else
    begin_seg(1'b1, MINV, 1'b0);
`endif
    for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b1);

    begin_seg(1'b1, 16384, 1'b0);
    for (int i = 0; i < 6 * R; i++) step(1'b1, (i % 4) != 3);

    begin_seg(1'b1, -16384, 1'b0);
    for (int i = 0; i < 6 * R; i++) step(1'b1, (i % 4) == 0);

    begin_seg(1'b1, 0, 1'b0);
    for (int i = 0; i < 6 * R; i++) begin
      step(1'b1, (i % 2) == 0);
      step(1'b0, (i % 2) == 0);
    end

    for (int i = 0; i < 20; i++) step(1'b1, (i % 2) == 0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'($urandom_range(0, 1)));
    for (int i = 20; i < 20 + 2 * R; i++) step(1'b1, (i % 2) == 0);

    begin_seg(1'b0, 0, 1'b0);
    for (int i = 0; i < 8 * R; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

    repeat (4) step(1'b0, 1'b0);
    check("no_missing_valid", due.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
